fx3_slave_fifo_arbiter: RTL and testbench

Sequences the FX3 synchronous Slave FIFO bus and shares it between two requesters: an OUT stream (FX3→FPGA, read socket) and an IN stream (FPGA→FX3, write socket).
- Drives all strobes, the socket address and the data-bus output enable.
- Honours FX3 address-to-flag latency and read latency.
- Issues PKTEND on packet boundaries.
- Sits between the mode/stream logic and the pad-level tristate in the slave FIFO top.

---
 rtl/fx3_slave_fifo_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fx3_slave_fifo_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_slave_fifo_arbiter.sv
// FX3 synchronous Slave FIFO sequencer: arbitrates the bus between the OUT (read)
// and IN (write) streams and drives registered strobes, socket address and data OE.
module fx3_slave_fifo_arbiter #(
    parameter int         DATA_W    = 32,
    parameter logic [1:0] RD_SOCK   = 2'd3,
    parameter logic [1:0] WR_SOCK   = 2'd0,
    parameter int         ADDR_LAT  = 3,
    parameter int         RD_LAT    = 2,
    parameter int         MAX_BURST = 256
) (
    input  logic              clk,
    input  logic              reset_from_fx3,
    input  logic              flaga,
    input  logic              flagb,
    input  logic              flagc,
    input  logic              flagd,
    output logic [1:0]        faddr,
    output logic              slcs_n,
    output logic              sloe_n,
    output logic              slrd_n,
    output logic              slwr_n,
    output logic              pktend_n,
    input  logic [DATA_W-1:0] fdata_in,
    output logic [DATA_W-1:0] fdata_out,
    output logic              fdata_oe,
    input  logic              rd_req,
    input  logic              rd_afull,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_pop
);

    localparam int CNT_W = $clog2(MAX_BURST + ADDR_LAT + RD_LAT + 2);
    localparam logic [CNT_W-1:0] ADDR_DONE  = CNT_W'(ADDR_LAT);
    localparam logic [CNT_W-1:0] DRAIN_DONE = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_BURST, RD_DRAIN, WR_ADDR, WR_BURST, TURN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                prio_wr_q, prio_wr_d;
    logic [1:0]          faddr_q, faddr_d;
    logic                slcs_n_q, sloe_n_q, slrd_n_q, slwr_n_q, pktend_n_q, fdata_oe_q;
    logic                slcs_n_d, sloe_n_d, slrd_n_d, slwr_n_d, pktend_n_d, fdata_oe_d;
    logic [DATA_W-1:0]   fdata_out_q, fdata_out_d;
    logic                pop;
    logic [RD_LAT-1:0]   vld_pipe_q;
    logic [RD_LAT:0]     vld_pipe;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_wr_d   = prio_wr_q;
        faddr_d     = faddr_q;
        fdata_out_d = fdata_out_q;
        pop         = 1'b0;
        slwr_n_d    = 1'b1;
        pktend_n_d  = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rd_req && !(wr_req && prio_wr_q)) begin
                    state_d = RD_ADDR;
                    faddr_d = RD_SOCK;
                    if (wr_req) prio_wr_d = 1'b1;
                end else if (wr_req) begin
                    state_d = WR_ADDR;
                    faddr_d = WR_SOCK;
                    if (rd_req) prio_wr_d = 1'b0;
                end
            end
            RD_ADDR, WR_ADDR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_DONE) begin
                    cnt_d = '0;
                    if (state_q == RD_ADDR) state_d = flaga ? RD_BURST : TURN;
                    else                    state_d = flagc ? WR_BURST : TURN;
                end
            end
            RD_BURST: begin
                // Every RD_BURST cycle has slrd_n low on the pads, so it counts as a pulse.
                cnt_d = cnt_q + 1'b1;
                if (!flaga || !flagb || rd_afull || cnt_d == BURST_MAX) begin
                    state_d = RD_DRAIN;
                    cnt_d   = '0;
                end
            end
            RD_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DRAIN_DONE) state_d = TURN;
            end
            WR_BURST: begin
                // pktend_n_q low means the previous pop carried wr_last.
                if (!wr_req || !flagc || !flagd || cnt_q == BURST_MAX || !pktend_n_q) begin
                    state_d = TURN;
                end else begin
                    pop         = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    fdata_out_d = wr_data;
                    slwr_n_d    = 1'b0;
                    pktend_n_d  = ~wr_last;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        slcs_n_d   = (state_d == IDLE) || (state_d == TURN);
        sloe_n_d   = !((state_d == RD_BURST) || (state_d == RD_DRAIN));
        slrd_n_d   = (state_d != RD_BURST);
        fdata_oe_d = (state_d == WR_BURST);
    end

    always_ff @(posedge clk or negedge reset_from_fx3) begin
        if (!reset_from_fx3) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prio_wr_q   <= 1'b0;
            faddr_q     <= WR_SOCK;
            slcs_n_q    <= 1'b1;
            sloe_n_q    <= 1'b1;
            slrd_n_q    <= 1'b1;
            slwr_n_q    <= 1'b1;
            pktend_n_q  <= 1'b1;
            fdata_oe_q  <= 1'b0;
            fdata_out_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_wr_q   <= prio_wr_d;
            faddr_q     <= faddr_d;
            slcs_n_q    <= slcs_n_d;
            sloe_n_q    <= sloe_n_d;
            slrd_n_q    <= slrd_n_d;
            slwr_n_q    <= slwr_n_d;
            pktend_n_q  <= pktend_n_d;
            fdata_oe_q  <= fdata_oe_d;
            fdata_out_q <= fdata_out_d;
        end
    end

    // Bit k of vld_pipe: the pad slrd_n was low k cycles ago; bit RD_LAT marks a word on fdata_in.
    assign vld_pipe = {vld_pipe_q, ~slrd_n_q};

    always_ff @(posedge clk or negedge reset_from_fx3) begin
        if (!reset_from_fx3) begin
            vld_pipe_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe[RD_LAT-1:0];
            rd_valid_q <= vld_pipe[RD_LAT];
            if (vld_pipe[RD_LAT]) rd_data_q <= fdata_in;
        end
    end

    assign faddr     = faddr_q;
    assign slcs_n    = slcs_n_q;
    assign sloe_n    = sloe_n_q;
    assign slrd_n    = slrd_n_q;
    assign slwr_n    = slwr_n_q;
    assign pktend_n  = pktend_n_q;
    assign fdata_oe  = fdata_oe_q;
    assign fdata_out = fdata_out_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_pop    = pop;

endmodule

// File: tb/tb_fx3_slave_fifo_arbiter.sv
// Bench for fx3_slave_fifo_arbiter: FX3 read-data model plus write source feed
// scoreboards; a negedge monitor checks pad traffic against them.
module tb_fx3_slave_fifo_arbiter;
    localparam int DW = 32;
    localparam int AL = 3;
    localparam int RL = 2;
    localparam int MB = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flaga = 1'b1, flagb = 1'b1, flagc = 1'b1, flagd = 1'b1;
    logic [1:0]    faddr;
    logic          slcs_n, sloe_n, slrd_n, slwr_n, pktend_n, fdata_oe, rd_valid, wr_pop;
    logic [DW-1:0] fdata_in = '0, fdata_out, rd_data, wr_data = '0;
    logic          rd_req = 1'b0, rd_afull = 1'b0, wr_req = 1'b0, wr_last = 1'b0;

    always #5 clk = ~clk;

    fx3_slave_fifo_arbiter #(
        .DATA_W(DW), .RD_SOCK(2'd3), .WR_SOCK(2'd0),
        .ADDR_LAT(AL), .RD_LAT(RL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset_from_fx3(rst_n),
        .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd),
        .faddr(faddr), .slcs_n(slcs_n), .sloe_n(sloe_n), .slrd_n(slrd_n),
        .slwr_n(slwr_n), .pktend_n(pktend_n),
        .fdata_in(fdata_in), .fdata_out(fdata_out), .fdata_oe(fdata_oe),
        .rd_req(rd_req), .rd_afull(rd_afull), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_data(wr_data), .wr_last(wr_last), .wr_pop(wr_pop)
    );

    typedef struct packed { logic [DW-1:0] data; logic last; } wword_t;
    wword_t        src_q[$];
    wword_t        exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    int            burst_log[$];
    logic          src_en = 1'b0;
    int total = 0, bad = 0;
    int n_slrd = 0, n_rdv = 0, n_slwr = 0, n_pkt = 0, n_pop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int n, input logic [DW-1:0] base, input logic last_on_end);
        for (int i = 0; i < n; i++)
            src_q.push_back('{data: base + DW'(i), last: last_on_end && (i == n - 1)});
    endtask

    task automatic wait_idle();
        int t = 0;
        int q = 0;
        while (slcs_n && t < 20) begin @(negedge clk); t++; end
        t = 0;
        while (q < 8 && t < 3000) begin
            @(negedge clk);
            q = slcs_n ? q + 1 : 0;
            t++;
        end
        chk("idle_reached", 32'(q >= 8), 32'd1);
    endtask

    // Write source: show-ahead head word, consumed on the edge that sees wr_pop.
    initial begin : source
        logic popped;
        forever begin
            @(negedge clk);
            popped = wr_pop;
            if (popped && src_q.size() > 0) begin
                exp_wr.push_back(src_q[0]);
                n_pop++;
            end
            @(posedge clk);
            if (popped && src_q.size() > 0) void'(src_q.pop_front());
            #1;
            wr_req  = src_en && (src_q.size() > 0);
            wr_data = (src_q.size() > 0) ? src_q[0].data : '0;
            wr_last = (src_q.size() > 0) ? src_q[0].last : 1'b0;
        end
    end

    // Monitor and FX3 read model: a word appears RL cycles after each slrd_n-low cycle.
    logic [RL:0] hist = '0;
    int rd_run = 0, wr_run = 0, rd_seq = 0;
    initial begin : monitor
        wword_t e;
        forever begin
            @(negedge clk);
            chk("no_rd_wr_overlap", 32'(!slrd_n && !slwr_n), 32'd0);
            chk("no_oe_contention", 32'(fdata_oe && !sloe_n), 32'd0);
            if (!slrd_n) begin n_slrd++; rd_run++; end
            else if (rd_run > 0) begin burst_log.push_back(rd_run); rd_run = 0; end
            if (!slwr_n) begin n_slwr++; wr_run++; end
            else if (wr_run > 0) begin burst_log.push_back(1000 + wr_run); wr_run = 0; end
            if (!pktend_n) begin
                n_pkt++;
                chk("pktend_with_slwr", 32'(slwr_n), 32'd0);
            end
            if (!slwr_n) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_data", fdata_out, e.data);
                    chk("wr_pktend", 32'(pktend_n), 32'(!e.last));
                    chk("wr_oe", 32'(fdata_oe), 32'd1);
                end
            end
            if (rd_valid) begin
                n_rdv++;
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end
            if (!rst_n) hist = '0;
            else        hist = {hist[RL-1:0], !slrd_n};
            if (hist[RL]) begin
                fdata_in = 32'hA500_0000 + DW'(rd_seq);
                exp_rd.push_back(fdata_in);
                rd_seq++;
            end else begin
                fdata_in = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, k, t, s0, v0, w0, p0, k0;
        logic bad_addr;
        // Reset held with both requests pending
        rd_req = 1'b1;
        push_pkt(2, 32'h1111_0000, 1'b1);
        src_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {27'd0, slcs_n, sloe_n, slrd_n, slwr_n, pktend_n}, 32'h1F);
        chk("rst_faddr", 32'(faddr), 32'd0);
        chk("rst_oe", 32'(fdata_oe), 32'd0);
        chk("rst_fdata_out", fdata_out, 32'd0);
        chk("rst_wr_pop", 32'(wr_pop), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (slrd_n && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        chk("first_strobe_latency", 32'(n >= AL + 2 && n < 50), 32'd1);
        chk("first_grant_read_addr", 32'(faddr), 32'd3);
        rd_req = 1'b0;
        flagb  = 1'b0;
        wait_idle();
        flagb = 1'b1;
        src_en = 1'b0;
        chk("rst_rd_pulses", 32'(n_slrd), 32'd1);
        chk("rst_rd_valids", 32'(n_rdv), 32'd1);
        chk("rst_wr_words", 32'(n_slwr), 32'd2);
        chk("rst_pktends", 32'(n_pkt), 32'd1);

        // Read burst cut by the partial flag after 20 pulses
        s0 = n_slrd; v0 = n_rdv;
        rd_req = 1'b1;
        k = 0; t = 0;
        while (k < 20 && t < 500) begin
            @(negedge clk);
            if (!slrd_n) k++;
            t++;
        end
        chk("rd_20_pulses_seen", 32'(k), 32'd20);
        flagb = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        chk("rd_stop_on_sample", 32'(slrd_n), 32'd1);
        chk("rd_drain1_oe", 32'(sloe_n), 32'd0);
        @(negedge clk);
        chk("rd_drain2_oe", 32'(sloe_n), 32'd0);
        @(negedge clk);
        chk("rd_turn_oe", 32'(sloe_n), 32'd1);
        wait_idle();
        flagb = 1'b1;
        chk("rd_pulse_count", 32'(n_slrd - s0), 32'd20);
        chk("rd_valid_count", 32'(n_rdv - v0), 32'd20);

        // 5-word write packet ending with PKTEND
        w0 = n_slwr; p0 = n_pop; k0 = n_pkt;
        push_pkt(5, 32'hC0DE_0000, 1'b1);
        src_en = 1'b1;
        wait_idle();
        src_en = 1'b0;
        chk("wr_pops", 32'(n_pop - p0), 32'd5);
        chk("wr_strobes", 32'(n_slwr - w0), 32'd5);
        chk("wr_pktends", 32'(n_pkt - k0), 32'd1);

        // Write socket not ready
        w0 = n_slwr; p0 = n_pop;
        flagc = 1'b0;
        push_pkt(1, 32'h7777_0000, 1'b1);
        src_en = 1'b1;
        bad_addr = 1'b0;
        repeat (30) begin @(negedge clk); if (faddr !== 2'd0) bad_addr = 1'b1; end
        chk("nr_faddr_wr", 32'(bad_addr), 32'd0);
        chk("nr_no_slwr", 32'(n_slwr - w0), 32'd0);
        chk("nr_no_pop", 32'(n_pop - p0), 32'd0);
        src_en = 1'b0;
        wait_idle();
        src_q.delete();
        flagc = 1'b1;
        flagb = 1'b0;
        rd_req = 1'b1;
        t = 0;
        while (slrd_n && t < 50) begin @(negedge clk); t++; end
        chk("nr_read_granted", 32'(slrd_n), 32'd0);
        chk("nr_read_faddr", 32'(faddr), 32'd3);
        rd_req = 1'b0;
        wait_idle();
        flagb = 1'b1;

        // Reset during the 4th word of a write burst
        k0 = n_pkt;
        push_pkt(6, 32'hBEE0_0000, 1'b1);
        src_en = 1'b1;
        k = 0; t = 0;
        while (k < 4 && t < 200) begin
            @(negedge clk);
            if (!slwr_n) k++;
            t++;
        end
        chk("mr_4th_word_seen", 32'(k), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mr_slwr_high", 32'(slwr_n), 32'd1);
        chk("mr_oe_low", 32'(fdata_oe), 32'd0);
        chk("mr_pktend_high", 32'(pktend_n), 32'd1);
        chk("mr_slcs_high", 32'(slcs_n), 32'd1);
        repeat (2) @(negedge clk);
        src_en = 1'b0;
        src_q.delete(); exp_wr.delete(); exp_rd.delete();
        chk("mr_no_pktend", 32'(n_pkt - k0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        w0 = n_slwr; k0 = n_pkt;
        push_pkt(2, 32'h4242_0000, 1'b1);
        src_en = 1'b1;
        wait_idle();
        src_en = 1'b0;
        chk("mr_restart_words", 32'(n_slwr - w0), 32'd2);
        chk("mr_restart_pktend", 32'(n_pkt - k0), 32'd1);

        // Arbitration: both requesters busy, bursts capped at MB
        burst_log.delete();
        push_pkt(60, 32'h5A00_0000, 1'b0);
        src_en = 1'b1;
        @(posedge clk); #2;
        rd_req = 1'b1;
        t = 0;
        while (burst_log.size() < 4 && t < 2000) begin @(negedge clk); t++; end
        rd_req = 1'b0; src_en = 1'b0;
        wait_idle();
        chk("arb_bursts_logged", 32'(burst_log.size() >= 4), 32'd1);
        if (burst_log.size() >= 4) begin
            chk("arb_burst0_rd", 32'(burst_log[0]), 32'(MB));
            chk("arb_burst1_wr", 32'(burst_log[1]), 32'(1000 + MB));
            chk("arb_burst2_rd", 32'(burst_log[2]), 32'(MB));
            chk("arb_burst3_wr", 32'(burst_log[3]), 32'(1000 + MB));
        end
        src_q.delete();
        chk("rd_scoreboard_empty", 32'(exp_rd.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
